nios2_oci_trace_fifo_ctrl: RTL

//  Write/read sequencer for the OCI trace FIFO. Packs up to three trace words per cycle (ITM, ATM, DTM)

---
 rtl/nios2_oci_trace_fifo_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/nios2_oci_trace_fifo_ctrl.sv
// OCI trace FIFO sequencer: packs ITM/ATM/DTM groups into a circular buffer, drops whole groups on overflow,
// drains one word per cycle. Define TRACE_FIFO_OVF_MARK_EN to write an OVF_MARK word when leaving overflow.
module nios2_oci_trace_fifo_ctrl #(
  parameter int              DW       = 36,
  parameter int              AW       = 4,
  parameter logic [DW-1:0]   OVF_MARK = 36'hF_FFFF_FFFF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          trace_en,
  input  logic          flush,
  input  logic          itm_valid,
  input  logic [DW-1:0] itm,
  input  logic          atm_valid,
  input  logic [DW-1:0] atm,
  input  logic          dtm_valid,
  input  logic [DW-1:0] dtm,
  output logic          tr_valid,
  output logic [DW-1:0] tr_data,
  input  logic          tr_ready,
  output logic [AW:0]   fifo_count,
  output logic          ovf_sticky,
  output logic [7:0]    drop_cnt
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] HALF_C  = (AW+1)'(DEPTH / 2);

`ifdef TRACE_FIFO_OVF_MARK_EN
  typedef enum logic [1:0] {IDLE, RUN, DROP, MARK} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;
`endif

  logic [DW-1:0] mem [DEPTH];

  state_t        state_reg;
  logic [AW-1:0] wrptr_reg;
  logic [AW-1:0] rdptr_reg;
  logic [AW:0]   count_reg;
  logic          ovf_sticky_reg;
  logic [7:0]    drop_cnt_reg;

  logic [1:0]    n_grp;
  logic [AW:0]   free;
  logic          ge2_free;
  logic          ge3_free;
  logic          fits;
  logic          accept;
  logic          mark_wr;
  logic          drop_grp;
  logic          pop;
  logic [1:0]    wr_n;
  logic [8:0]    drop_sum;
  logic [DW-1:0] lane_data [3];
  logic [2:0]    lane_en;
  logic [AW-1:0] slot_addr [3];

  assign n_grp    = {1'b0, itm_valid} + {1'b0, atm_valid} + {1'b0, dtm_valid};
  assign free     = DEPTH_C - count_reg;
  assign ge2_free = (free >= (AW+1)'(2));
  assign ge3_free = (free >= (AW+1)'(3));

  always_comb begin
    fits = 1'b0;
    unique case (n_grp)
      2'd0: fits = 1'b1;
      2'd1: fits = (free != '0);
      2'd2: fits = ge2_free;
      2'd3: fits = ge3_free;
    endcase
  end

  assign tr_valid = (count_reg != '0);
  assign pop      = tr_valid && tr_ready && !flush;
  assign accept   = !flush && (state_reg == RUN) && trace_en && fits;

`ifdef TRACE_FIFO_OVF_MARK_EN
  assign mark_wr  = !flush && (state_reg == MARK);
  assign drop_grp = !flush && (n_grp != 2'd0) &&
                    (((state_reg == RUN) && trace_en && !fits) ||
                     (state_reg == DROP) || (state_reg == MARK));
`else
  assign mark_wr  = 1'b0;
  assign drop_grp = !flush && (n_grp != 2'd0) &&
                    (((state_reg == RUN) && trace_en && !fits) || (state_reg == DROP));
`endif

  assign wr_n     = mark_wr ? 2'd1 : (accept ? n_grp : 2'd0);
  assign drop_sum = {1'b0, drop_cnt_reg} + {7'd0, n_grp};

  // Lane k carries the k-th present word in ITM, ATM, DTM order; the marker displaces lane 0.
  assign lane_data[0] = mark_wr   ? OVF_MARK :
                        itm_valid ? itm      :
                        atm_valid ? atm      : dtm;
  assign lane_data[1] = (itm_valid && atm_valid) ? atm : dtm;
  assign lane_data[2] = dtm;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      assign lane_en[gi]   = (wr_n > 2'(gi));
      assign slot_addr[gi] = wrptr_reg + AW'(gi);
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (lane_en[i]) mem[slot_addr[i]] <= lane_data[i];
    end
  end

  assign tr_data    = mem[rdptr_reg];
  assign fifo_count = count_reg;
  assign ovf_sticky = ovf_sticky_reg;
  assign drop_cnt   = drop_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      wrptr_reg      <= '0;
      rdptr_reg      <= '0;
      count_reg      <= '0;
      ovf_sticky_reg <= 1'b0;
      drop_cnt_reg   <= '0;
    end else if (flush) begin
      state_reg      <= IDLE;
      wrptr_reg      <= '0;
      rdptr_reg      <= '0;
      count_reg      <= '0;
      ovf_sticky_reg <= 1'b0;
      drop_cnt_reg   <= '0;
    end else begin
      wrptr_reg <= wrptr_reg + AW'(wr_n);
      rdptr_reg <= rdptr_reg + AW'(pop);
      count_reg <= count_reg + (AW+1)'(wr_n) - (AW+1)'(pop);

      if (drop_grp) begin
        ovf_sticky_reg <= 1'b1;
        drop_cnt_reg   <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end

      // Recovery uses the registered free space, so leaving DROP needs the drain to catch up to half.
      unique case (state_reg)
        IDLE: if (trace_en) state_reg <= RUN;
        RUN: begin
          if (!trace_en)                     state_reg <= IDLE;
          else if (n_grp != 2'd0 && !fits)   state_reg <= DROP;
        end
        DROP: begin
          if (!trace_en)                     state_reg <= IDLE;
`ifdef TRACE_FIFO_OVF_MARK_EN
          else if (free >= HALF_C)           state_reg <= MARK;
`else
          else if (free >= HALF_C)           state_reg <= RUN;
`endif
        end
`ifdef TRACE_FIFO_OVF_MARK_EN
        MARK: state_reg <= RUN;
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
